// File: rtl/matmul_tile_sequencer.sv
// Tile sequencer feeding the multi-MAC core: walks C tiles row-major,
// steps the inner dimension, and forwards finished accumulators to the output buffer.
module matmul_tile_sequencer #(
    parameter int WIDTH           = 16,
    parameter int CHUNK_SIZE      = 4,
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 8,
    parameter int ROW_SIZE_MAT_A  = 10,
    parameter int COL_SIZE_MAT_B  = 6,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        systolic_finish,
    input  logic                        accumulator_done,
    input  logic [WIDTH*CHUNK_SIZE-1:0] acc_in,
    output logic [ADDR_WIDTH-1:0]       counter_A,
    output logic [ADDR_WIDTH-1:0]       counter_B,
    output logic                        core_rst_n,
    output logic                        reset_acc,
    output logic                        wr_en,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic [WIDTH*CHUNK_SIZE-1:0] wr_data,
    output logic                        busy,
    output logic                        done
);

    localparam int DW        = WIDTH * CHUNK_SIZE;
    localparam int K_STEPS   = INNER_DIMENSION / BLOCK_SIZE;
    localparam int ROW_TILES = ROW_SIZE_MAT_A / BLOCK_SIZE;
    localparam int COL_TILES = COL_SIZE_MAT_B / BLOCK_SIZE;

    localparam logic [ADDR_WIDTH-1:0] LP_K      = ADDR_WIDTH'(K_STEPS);
    localparam logic [ADDR_WIDTH-1:0] LP_COLS   = ADDR_WIDTH'(COL_TILES);
    localparam logic [ADDR_WIDTH-1:0] LP_K_LAST = ADDR_WIDTH'(K_STEPS - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_R_LAST = ADDR_WIDTH'(ROW_TILES - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_C_LAST = ADDR_WIDTH'(COL_TILES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RUN,
        WAIT_ACC,
        DONE
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_k;
    logic [ADDR_WIDTH-1:0]   r_row;
    logic [ADDR_WIDTH-1:0]   r_col;
    logic [ADDR_WIDTH-1:0]   r_counter_a;
    logic [ADDR_WIDTH-1:0]   r_counter_b;
    logic                    r_core_rst_n;
    logic                    r_reset_acc;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DW-1:0]           r_wr_data;
    logic                    r_busy;
    logic                    r_done;

    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   w_k_nxt;
    logic [ADDR_WIDTH-1:0]   w_row_nxt;
    logic [ADDR_WIDTH-1:0]   w_col_nxt;
    logic                    w_wr;
    logic                    w_last_k;
    logic                    w_last_row;
    logic                    w_last_col;

    assign w_last_k   = (r_k == LP_K_LAST);
    assign w_last_row = (r_row == LP_R_LAST);
    assign w_last_col = (r_col == LP_C_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_wr        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_k_nxt     = '0;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: w_state_nxt = RUN;
            RUN: begin
                if (systolic_finish) begin
                    if (!w_last_k) begin
                        w_k_nxt     = r_k + 1'b1;
                        w_state_nxt = FETCH;
                    end else if (accumulator_done) begin
                        w_wr = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_ACC;
                    end
                end
            end
            WAIT_ACC: begin
                if (accumulator_done) begin
                    w_wr = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Tile advance; the final tile wraps to 0 so addresses never overrun.
        if (w_wr) begin
            w_k_nxt = '0;
            if (w_last_col) begin
                w_col_nxt = '0;
                w_row_nxt = w_last_row ? '0 : r_row + 1'b1;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
            w_state_nxt = (w_last_row && w_last_col) ? DONE : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_counter_a  <= '0;
            r_counter_b  <= '0;
            r_core_rst_n <= 1'b0;
            r_reset_acc  <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_counter_a  <= w_k_nxt + LP_K * w_row_nxt;
            r_counter_b  <= w_k_nxt + LP_K * w_col_nxt;
            r_core_rst_n <= (w_state_nxt == RUN);
            r_reset_acc  <= (w_state_nxt == IDLE) || (w_state_nxt == DONE) ||
                            ((w_state_nxt == FETCH) && (w_k_nxt == '0));
            r_wr_en      <= w_wr;
            if (w_wr) begin
                r_wr_addr <= r_row * LP_COLS + r_col;
                r_wr_data <= acc_in;
            end
            r_busy       <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
            r_done       <= (w_state_nxt == DONE);
        end
    end

    assign counter_A  = r_counter_a;
    assign counter_B  = r_counter_b;
    assign core_rst_n = r_core_rst_n;
    assign reset_acc  = r_reset_acc;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Bench for matmul_tile_sequencer: table of run scenarios driven by a
// lock-step core model, expected traces computed from tile/k arithmetic.
module tb_matmul_tile_sequencer;

    localparam int KS = 4;
    localparam int CT = 3;
    localparam int NT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        systolic_finish = 1'b0;
    logic        accumulator_done = 1'b0;
    logic [63:0] acc_in = '0;
    logic [15:0] counter_A;
    logic [15:0] counter_B;
    logic        core_rst_n;
    logic        reset_acc;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;

    matmul_tile_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .systolic_finish  (systolic_finish),
        .accumulator_done (accumulator_done),
        .acc_in           (acc_in),
        .counter_A        (counter_A),
        .counter_B        (counter_B),
        .core_rst_n       (core_rst_n),
        .reset_acc        (reset_acc),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en === 1'b1) n_wr++;

    // fin_dly/gap of -1 means randomize per step; -1 tiles disable the feature
    typedef struct {
        int fin_dly;
        int gap;
        int spur_tile;
        int abort_tile;
        int abort_k;
        int exp_writes;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_cntA"}, counter_A, 0);
        chk({nm, "_cntB"}, counter_B, 0);
        chk({nm, "_core_rst_n"}, core_rst_n, 0);
        chk({nm, "_reset_acc"}, reset_acc, 1);
        chk({nm, "_wr_en"}, wr_en, 0);
        chk({nm, "_wr_addr"}, wr_addr, 0);
        chk({nm, "_wr_data"}, wr_data, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic do_run(input int vi, input vec_t c);
        int base;
        int d;
        int g;
        int row;
        int col;
        bit stop;
        logic [63:0] data;
        base = n_wr;
        stop = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int t = 0; t < NT && !stop; t++) begin
            row = t / CT;
            col = t % CT;
            for (int k = 0; k < KS && !stop; k++) begin
                chk("fetch_core_rst_n", core_rst_n, 0);
                chk("fetch_reset_acc", reset_acc, (k == 0) ? 1 : 0);
                chk("fetch_cntA", counter_A, k + KS * row);
                chk("fetch_cntB", counter_B, k + KS * col);
                @(negedge clk);
                chk("run_core_rst_n", core_rst_n, 1);
                chk("run_reset_acc", reset_acc, 0);
                chk("run_cntA", counter_A, k + KS * row);
                chk("run_cntB", counter_B, k + KS * col);
                if (core_rst_n !== 1'b1) begin
                    stop = 1'b1;
                    break;
                end
                if (t == c.abort_tile && k == c.abort_k) begin
                    #2 rst_n = 1'b0;
                    #1 chk_reset_vals("async_rst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk("post_rst_busy", busy, 0);
                    stop = 1'b1;
                    break;
                end
                if (t == c.spur_tile && k == 1) begin
                    accumulator_done = 1'b1;
                    start = 1'b1;
                    @(negedge clk);
                    accumulator_done = 1'b0;
                    start = 1'b0;
                    chk("spur_wr_en", wr_en, 0);
                    chk("spur_busy", busy, 1);
                    chk("spur_cntA", counter_A, k + KS * row);
                end
                d = (c.fin_dly < 0) ? int'($urandom_range(0, 6)) : c.fin_dly;
                repeat (d) @(negedge clk);
                g = (c.gap < 0) ? int'($urandom_range(0, 3)) : c.gap;
                data = (vi == 0 && t == 0) ? 64'h0001_0002_0003_0004
                                           : {$urandom, $urandom};
                systolic_finish = 1'b1;
                if (k == KS - 1 && g == 0) begin
                    accumulator_done = 1'b1;
                    acc_in = data;
                end
                @(negedge clk);
                systolic_finish = 1'b0;
                accumulator_done = 1'b0;
                if (k < KS - 1) begin
                    chk("step_wr_en", wr_en, 0);
                    continue;
                end
                if (g > 0) begin
                    chk("wait_wr_en", wr_en, 0);
                    chk("wait_core_rst_n", core_rst_n, 0);
                    repeat (g - 1) @(negedge clk);
                    accumulator_done = 1'b1;
                    acc_in = data;
                    @(negedge clk);
                    accumulator_done = 1'b0;
                end
                chk("tile_wr_en", wr_en, 1);
                chk("tile_wr_addr", wr_addr, t);
                chk("tile_wr_data", wr_data, data);
                if (t == NT - 1) begin
                    chk("last_done", done, 1);
                    chk("last_busy", busy, 0);
                    @(negedge clk);
                    chk("idle_done", done, 0);
                    chk("idle_busy", busy, 0);
                    chk("idle_wr_en", wr_en, 0);
                end else begin
                    chk("mid_done", done, 0);
                    chk("mid_busy", busy, 1);
                end
            end
        end
        #1 chk("run_write_count", n_wr - base, c.exp_writes);
    endtask

    initial begin
        tbl[0] = '{fin_dly: 6, gap: 2, spur_tile: -1, abort_tile: -1,
                   abort_k: -1, exp_writes: 15};
        tbl[1] = '{fin_dly: 2, gap: 0, spur_tile: -1, abort_tile: -1,
                   abort_k: -1, exp_writes: 15};
        tbl[2] = '{fin_dly: -1, gap: -1, spur_tile: 4, abort_tile: -1,
                   abort_k: -1, exp_writes: 15};
        tbl[3] = '{fin_dly: 3, gap: 1, spur_tile: -1, abort_tile: 7,
                   abort_k: 2, exp_writes: 7};
        tbl[4] = '{fin_dly: -1, gap: -1, spur_tile: -1, abort_tile: -1,
                   abort_k: -1, exp_writes: 15};

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("idle");
        for (int i = 0; i < 5; i++) do_run(i, tbl[i]);
        repeat (3) @(negedge clk);
        chk("final_busy", busy, 0);
        chk("final_done", done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
Control stage directly upstream of the multi-MAC toplevel. It walks the tiled output matrix C in row-major order and, for each C tile, steps through the inner dimension. For every step it drives the A/B chunk addresses into the input RAMs and sequences the core's rst_n and reset_acc. It captures each finished accumulator word and writes it into the output buffer with its tile index. This replaces free-running, edge-triggered counter logic with a single synchronous FSM.

Parameters:
WIDTH, 16, element width; also sets the captured data width.
CHUNK_SIZE, 4, elements per RAM word and per core output word.
BLOCK_SIZE, 2, systolic array dimension.
INNER_DIMENSION, 8, shared dimension of A and B. K_STEPS = INNER_DIMENSION/BLOCK_SIZE (default 4).
ROW_SIZE_MAT_A, 10, rows of A. ROW_TILES = ROW_SIZE_MAT_A/BLOCK_SIZE (default 5).
COL_SIZE_MAT_B, 6, columns of B. COL_TILES = COL_SIZE_MAT_B/BLOCK_SIZE (default 3).
ADDR_WIDTH, 16, width of all address outputs.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that launches a full matrix multiply.
systolic_finish  in  1  core has finished one chunk step.
accumulator_done  in  1  core accumulator holds a complete C tile.
acc_in  in  WIDTH*CHUNK_SIZE  core output word.
counter_A  out  ADDR_WIDTH  RAM A chunk address.
counter_B  out  ADDR_WIDTH  RAM B chunk address.
core_rst_n  out  1  active-low run/reset to the core.
reset_acc  out  1  clear for the core accumulator.
wr_en  out  1  one-cycle output-buffer write strobe.
wr_addr  out  ADDR_WIDTH  C tile index, row*COL_TILES+col.
wr_data  out  WIDTH*CHUNK_SIZE  captured acc_in.
busy  out  1  high from the cycle after start is accepted until DONE.
done  out  1  one-cycle pulse after the last tile is written.

Behaviour:
- Reset values: counter_A=0, counter_B=0, core_rst_n=0, reset_acc=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- Reset values: internal k=0, row=0, col=0, state=IDLE.
- All outputs are registered.
- Address rule, applied in every state: counter_A = k + K_STEPS*row and counter_B = k + K_STEPS*col.
- States: IDLE, FETCH, RUN, WAIT_ACC, DONE.
- IDLE:
  - core_rst_n=0, reset_acc=1.
  - start=1 -> clear k, row and col, go to FETCH.
- FETCH: exactly 1 cycle.
  - Covers the 1-cycle synchronous RAM read latency.
  - core_rst_n=0.
  - reset_acc=1 only when k==0, otherwise 0.
  - Next state is RUN.
- RUN:
  - core_rst_n=1, reset_acc=0.
  - On systolic_finish with k<K_STEPS-1: k++, go to FETCH.
  - On systolic_finish with k==K_STEPS-1: go to WAIT_ACC.
  - If accumulator_done is also high in that same cycle, perform the tile write immediately (see below) and skip WAIT_ACC.
- WAIT_ACC:
  - core_rst_n=0.
  - On accumulator_done, perform the tile write.
- Tile write:
  - In the cycle after accumulator_done is sampled: wr_en=1, wr_data=acc_in as sampled, wr_addr = row*COL_TILES+col.
  - In the same cycle, advance the tile. k=0. If col==COL_TILES-1, then col=0 and row++; otherwise col++.
  - After the last tile (row==ROW_TILES-1 and col==COL_TILES-1), go to DONE. Otherwise go to FETCH.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
- Ignored inputs:
  - accumulator_done outside WAIT_ACC and the last-k RUN cycle.
  - systolic_finish outside RUN.
  - start while busy.
- Default-parameter counts: 15 tiles per run, with wr_addr running 0..14.
- Address ranges at default parameters: counter_A max = 3+4*4 = 19; counter_B max = 3+4*2 = 11.
- Asynchronous reset mid-run returns everything to reset values immediately. No partial write is issued. A new start is required.
- Back-to-back runs: start in the cycle after done is accepted.

Test Plan:
1. Reset, then start; core model pulses systolic_finish 6 cycles into each RUN and accumulator_done 2 cycles after the last-k finish -> exactly 15 wr_en pulses, wr_addr 0,1,...,14 in order, then one done pulse, busy low.
2. Address trace for tile (row=2, col=1) -> counter_A sequence 8,9,10,11; counter_B sequence 4,5,6,7; reset_acc=1 only during the k=0 FETCH.
3. acc_in = 64'h0001_0002_0003_0004 driven in the accumulator_done cycle -> wr_data equals 64'h0001_0002_0003_0004 one cycle later.
4. accumulator_done asserted in the same cycle as the last-k systolic_finish -> write occurs the next cycle, WAIT_ACC is never entered, and no extra stall cycle appears.
5. Spurious accumulator_done during RUN at k=1, plus start pulsed while busy -> no wr_en, k continues to 2, and the run is not restarted.
6. rst_n dropped during tile 7 at k=2 -> all outputs return to reset values asynchronously; a new start restarts at wr_addr=0 with counter_A=0 and counter_B=0.
